// File: rtl/core_mem_arb_pkg.sv
// Shared core defines for the memory arbiter: FSM state encodings, byte-enable constant and grant IDs.
package core_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_e;

    localparam logic [3:0] MEM_BE_FULL = 4'hF;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/core_mem_arb_if.sv
// Bundle of the fetch, data and shared-memory signals around core_mem_arb.
// master = core pipeline plus memory (environment), slave = the arbiter.
interface core_mem_arb_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        if_ack;
    logic        d_ack;
    logic [31:0] rdata;
    logic        stall_if_out;
    logic        stall_mem_out;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  if_ack, d_ack, rdata, stall_if_out, stall_mem_out
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output if_ack, d_ack, rdata, stall_if_out, stall_mem_out
    );

endinterface

// File: rtl/core_mem_arb.sv
// Arbiter sharing one memory port between instruction fetch and the MEM stage.
// Define CORE_ARB_RR_EN for round-robin on collisions; otherwise data always beats fetch.
module core_mem_arb
    import core_mem_arb_pkg::*;
(
    input logic           clk,
    input logic           rst,
    core_mem_arb_if.slave bus
);

    arb_state_e state;
    logic       grant_d;

`ifdef CORE_ARB_RR_EN
    logic last_grant;

    // Data wins when it asks alone, or on a collision when fetch was served last.
    always_comb begin
        grant_d = bus.d_req & (~bus.if_req | (last_grant == GRANT_IF));
    end
`else
    always_comb begin
        grant_d = bus.d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_be    <= 4'h0;
`ifdef CORE_ARB_RR_EN
            last_grant    <= GRANT_IF;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req | bus.d_req) begin
                        bus.mem_req <= 1'b1;
                        if (grant_d) begin
                            state         <= D_BUSY;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_be    <= bus.d_be;
                        end else begin
                            state         <= IF_BUSY;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= 32'h0;
                            bus.mem_be    <= MEM_BE_FULL;
                        end
`ifdef CORE_ARB_RR_EN
                        last_grant <= grant_d ? GRANT_D : GRANT_IF;
`endif
                    end
                end
                IF_BUSY, D_BUSY: begin
                    // Command stays frozen until memory completes; requester drops are ignored.
                    if (bus.mem_ack) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Acks are masked by reset so an abandoned transaction never completes.
    always_comb begin
        bus.if_ack        = ~rst & (state == IF_BUSY) & bus.mem_ack;
        bus.d_ack         = ~rst & (state == D_BUSY) & bus.mem_ack;
        bus.rdata         = bus.mem_rdata;
        bus.stall_if_out  = bus.if_req & ~bus.if_ack;
        bus.stall_mem_out = bus.d_req & ~bus.d_ack;
    end

endmodule

// File: tb/tb_core_mem_arb.sv
// Directed self-checking bench for core_mem_arb; builds with or without CORE_ARB_RR_EN.
module tb_core_mem_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    core_mem_arb_if bus ();

    core_mem_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.d_be      = 4'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %0h exp 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %0h exp 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata got %h exp 0", bus.mem_wdata); end
        checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_be got %h exp 0", bus.mem_be); end
        checks++; if (bus.stall_if_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_if got %0h exp 0", bus.stall_if_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        #1;
        checks++; if (bus.stall_if_out !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_req got %0h exp 1", bus.stall_if_out); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mem_req c%0d got %0h exp 1", i, bus.mem_req); end
            checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL fetch_mem_addr c%0d got %h exp 100", i, bus.mem_addr); end
            checks++; if (bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_be_we c%0d got %h/%0h exp f/0", i, bus.mem_be, bus.mem_we); end
            checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_early_ack c%0d got %0h exp 0", i, bus.if_ack); end
            tick();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        #1;
        checks++; if (bus.if_ack !== 1'b1) begin errors++; $display("[TB] FAIL fetch_if_ack got %0h exp 1", bus.if_ack); end
        checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_d_ack got %0h exp 0", bus.d_ack); end
        checks++; if (bus.rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL fetch_rdata got %h exp 12345678", bus.rdata); end
        checks++; if (bus.stall_if_out !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall_ack got %0h exp 0", bus.stall_if_out); end
        tick();
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mem_req_done got %0h exp 0", bus.mem_req); end
        checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_ack_single got %0h exp 0", bus.if_ack); end
        tick();
    endtask

    task automatic test_store();
        int pulses;
        pulses      = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0040;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_be    = 4'b0011;
        tick();
        bus.d_wdata = 32'h5555_AAAA;
        bus.d_be    = 4'b1100;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL store_req_we c%0d got %0h/%0h exp 1/1", i, bus.mem_req, bus.mem_we); end
            checks++; if (bus.mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL store_addr c%0d got %h exp 40", i, bus.mem_addr); end
            checks++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store_wdata c%0d got %h exp deadbeef", i, bus.mem_wdata); end
            checks++; if (bus.mem_be !== 4'b0011) begin errors++; $display("[TB] FAIL store_be c%0d got %h exp 3", i, bus.mem_be); end
            checks++; if (bus.stall_mem_out !== 1'b1) begin errors++; $display("[TB] FAIL store_stall c%0d got %0h exp 1", i, bus.stall_mem_out); end
            tick();
        end
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.d_ack === 1'b1) pulses++;
            checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("[TB] FAIL store_if_ack c%0d got %0h exp 0", i, bus.if_ack); end
            tick();
            bus.mem_ack = 1'b0;
            bus.d_req   = 1'b0;
        end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL store_d_ack_pulses got %0d exp 1", pulses); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL store_mem_req_done got %0h exp 0", bus.mem_req); end
        bus.d_we = 1'b0;
    endtask

`ifndef CORE_ARB_RR_EN
    task automatic test_collision_fixed();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_0300;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_2000;
        bus.d_be   = 4'hF;
        tick();
        checks++; if (bus.mem_addr !== 32'h2000 || bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL coll_first_grant got %h/%0h exp 2000/1", bus.mem_addr, bus.mem_req); end
        checks++; if (bus.stall_if_out !== 1'b1) begin errors++; $display("[TB] FAIL coll_stall_if_a got %0h exp 1", bus.stall_if_out); end
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.d_ack !== 1'b1 || bus.if_ack !== 1'b0) begin errors++; $display("[TB] FAIL coll_d_ack got d%0h i%0h exp d1 i0", bus.d_ack, bus.if_ack); end
        checks++; if (bus.stall_if_out !== 1'b1 || bus.stall_mem_out !== 1'b0) begin errors++; $display("[TB] FAIL coll_stalls got i%0h m%0h exp i1 m0", bus.stall_if_out, bus.stall_mem_out); end
        tick();
        bus.mem_ack = 1'b0;
        bus.d_req   = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL coll_idle_gap got %0h exp 0", bus.mem_req); end
        checks++; if (bus.stall_if_out !== 1'b1) begin errors++; $display("[TB] FAIL coll_stall_if_b got %0h exp 1", bus.stall_if_out); end
        tick();
        checks++; if (bus.mem_addr !== 32'h300 || bus.mem_be !== 4'hF || bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL coll_second_grant got %h/%h/%0h exp 300/f/1", bus.mem_addr, bus.mem_be, bus.mem_req); end
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.if_ack !== 1'b1) begin errors++; $display("[TB] FAIL coll_if_ack got %0h exp 1", bus.if_ack); end
        tick();
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        tick();
    endtask
`else
    task automatic test_collision_rr();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h0000_2000;
        exp_addr[1] = 32'h0000_0300;
        exp_addr[2] = 32'h0000_2000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h0000_0300;
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b0;
            bus.d_addr  = 32'h0000_2000;
            tick();
            checks++; if (bus.mem_addr !== exp_addr[k]) begin errors++; $display("[TB] FAIL rr_grant%0d got %h exp %h", k, bus.mem_addr, exp_addr[k]); end
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
            bus.if_req  = 1'b0;
            bus.d_req   = 1'b0;
            tick();
        end
    endtask
`endif

    task automatic test_reset_mid();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b1;
        bus.d_addr = 32'h0000_0080;
        bus.d_wdata = 32'hCAFE_F00D;
        bus.d_be   = 4'hF;
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy got %0h exp 1", bus.mem_req); end
        rst         = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ack_in_rst got %0h exp 0", bus.d_ack); end
        bus.mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_cleared got %0h/%h exp 0/0", bus.mem_req, bus.mem_addr); end
        bus.d_req   = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_late_ack got %0h exp 0", bus.d_ack); end
        tick();
        bus.mem_ack = 1'b0;
        bus.d_we    = 1'b0;
        tick();
    endtask

    task automatic test_spurious_ack();
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL spur_ack got i%0h d%0h exp 0/0", bus.if_ack, bus.d_ack); end
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL spur_mem_req got %0h exp 0", bus.mem_req); end
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0500;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h500) begin errors++; $display("[TB] FAIL spur_then_fetch got %0h/%h exp 1/500", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.if_ack !== 1'b1) begin errors++; $display("[TB] FAIL spur_fetch_ack got %0h exp 1", bus.if_ack); end
        tick();
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_store();
`ifndef CORE_ARB_RR_EN
        test_collision_fixed();
`else
        test_collision_rr();
`endif
        test_reset_mid();
        test_spurious_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
